// File: rtl/id_fwd_unit_pkg.sv
// Shared types for the ID-stage forwarding unit: shadow slot record,
// operand source select and the hard-wired zero register constant.
package id_fwd_unit_pkg;

    // Slot rd field is wide enough for any REG_AW up to 8.
    localparam int SLOT_RD_W = 8;

    localparam logic [SLOT_RD_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                 valid;
        logic [SLOT_RD_W-1:0] rd;
        logic                 reg_write;
        logic                 mem_read;
    } slot_t;

    typedef enum logic [1:0] {
        SRC_RF,
        SRC_EX,
        SRC_MEM,
        SRC_WB
    } src_e;

    function automatic logic slot_hit(slot_t s, logic [SLOT_RD_W-1:0] a);
        return s.valid && s.reg_write && (s.rd == a) && (a != REG_ZERO);
    endfunction

endpackage

// File: rtl/id_fwd_unit_fwd_port_sel.sv
// One read port: youngest-producer match, operand mux, hazard flag.
// Ports: addr/use_en/rf_data from ID, EX/MEM/WB slots and results, data/hazard out.
module fwd_port_sel
    import id_fwd_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              valid,
    input  logic              is_branch,
    input  logic [REG_AW-1:0] addr,
    input  logic              use_en,
    input  logic [DATA_W-1:0] rf_data,
    input  slot_t             ex_slot,
    input  slot_t             mem_slot,
    input  slot_t             wb_slot,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] data,
    output logic              hazard
);

    logic [SLOT_RD_W-1:0] a;
    logic ex_hit, mem_hit, wb_hit;
    src_e src;

    assign a       = SLOT_RD_W'(addr);
    assign ex_hit  = slot_hit(ex_slot, a);
    assign mem_hit = slot_hit(mem_slot, a);
    assign wb_hit  = slot_hit(wb_slot, a);

    // Several slots may hold the same rd; the youngest wins.
    always_comb begin
        src = SRC_RF;
        if (ex_hit)       src = SRC_EX;
        else if (mem_hit) src = SRC_MEM;
        else if (wb_hit)  src = SRC_WB;
    end

    always_comb begin
        data = rf_data;
        unique case (src)
            SRC_EX:  data = ex_result;
            SRC_MEM: data = mem_result;
            SRC_WB:  data = wb_data;
            default: data = rf_data;
        endcase
    end

    // Load data is only ready from MEM; a branch compare needs
    // one more stage of slack than a normal operand.
    always_comb begin
        hazard = 1'b0;
        if (valid && use_en) begin
            hazard = (ex_hit && ex_slot.mem_read)
                  || (is_branch && ex_hit)
                  || (is_branch && mem_hit && mem_slot.mem_read);
        end
    end

endmodule

// File: rtl/id_fwd_unit.sv
// ID-stage operand forwarding and load-use/branch hazard unit.
// Ports: ID read/dest info, flush, EX/MEM/WB results in; fwd_data_o, stall_o out;
// stall_cnt_o only when FWD_STATS_EN is defined.
module id_fwd_unit
    import id_fwd_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int NUM_RD = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     id_valid_i,
    input  logic [NUM_RD*REG_AW-1:0] id_rs_addr_i,
    input  logic [NUM_RD-1:0]        id_rs_use_i,
    input  logic [NUM_RD*DATA_W-1:0] id_rs_data_i,
    input  logic [REG_AW-1:0]        id_rd_addr_i,
    input  logic                     id_reg_write_i,
    input  logic                     id_mem_read_i,
    input  logic                     id_is_branch_i,
    input  logic                     flush_i,
    input  logic [DATA_W-1:0]        ex_result_i,
    input  logic [DATA_W-1:0]        mem_result_i,
    input  logic [DATA_W-1:0]        wb_data_i,
    output logic [NUM_RD*DATA_W-1:0] fwd_data_o,
    output logic                     stall_o
`ifdef FWD_STATS_EN
    ,
    output logic [15:0]              stall_cnt_o
`endif
);

    slot_t ex_q, mem_q, wb_q, id_slot;
    logic [NUM_RD-1:0] hazard;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_port
        fwd_port_sel #(
            .DATA_W(DATA_W),
            .REG_AW(REG_AW)
        ) u_sel (
            .valid     (id_valid_i),
            .is_branch (id_is_branch_i),
            .addr      (id_rs_addr_i[k*REG_AW +: REG_AW]),
            .use_en    (id_rs_use_i[k]),
            .rf_data   (id_rs_data_i[k*DATA_W +: DATA_W]),
            .ex_slot   (ex_q),
            .mem_slot  (mem_q),
            .wb_slot   (wb_q),
            .ex_result (ex_result_i),
            .mem_result(mem_result_i),
            .wb_data   (wb_data_i),
            .data      (fwd_data_o[k*DATA_W +: DATA_W]),
            .hazard    (hazard[k])
        );
    end

    // A flushed instruction is dead, so it must never hold the pipe.
    assign stall_o = (|hazard) && !flush_i;

    always_comb begin
        id_slot.valid     = id_valid_i && !stall_o && !flush_i;
        id_slot.rd        = SLOT_RD_W'(id_rd_addr_i);
        id_slot.reg_write = id_reg_write_i;
        id_slot.mem_read  = id_mem_read_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= id_slot;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

`ifdef FWD_STATS_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            cnt_q <= '0;
        else if (stall_o && cnt_q != 16'hFFFF)
            cnt_q <= cnt_q + 16'd1;
    end

    assign stall_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_id_fwd_unit.sv
// Randomized + directed bench for id_fwd_unit against an age-based model.
// Model: in-flight history by age, youngest producer, ready-age rule.
module tb_id_fwd_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [9:0]  rs_addr;
    logic [1:0]  rs_use;
    logic [63:0] rs_data;
    logic [4:0]  rd_addr;
    logic        reg_write, mem_read, is_branch, flush;
    logic [31:0] ex_res, mem_res, wb_dat;
    logic [63:0] fwd;
    logic        stall;
`ifdef FWD_STATS_EN
    logic [15:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    id_fwd_unit dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .id_valid_i    (id_valid),
        .id_rs_addr_i  (rs_addr),
        .id_rs_use_i   (rs_use),
        .id_rs_data_i  (rs_data),
        .id_rd_addr_i  (rd_addr),
        .id_reg_write_i(reg_write),
        .id_mem_read_i (mem_read),
        .id_is_branch_i(is_branch),
        .flush_i       (flush),
        .ex_result_i   (ex_res),
        .mem_result_i  (mem_res),
        .wb_data_i     (wb_dat),
        .fwd_data_o    (fwd),
        .stall_o       (stall)
`ifdef FWD_STATS_EN
        ,
        .stall_cnt_o   (stall_cnt)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // hist[a] = instruction that entered EX a+1 edges ago (a=0 is EX).
    typedef struct {
        bit v;
        int rd;
        bit wr;
        bit ld;
    } rec_t;

    rec_t hist[3];
    int   m_cnt = 0;

    logic [31:0] g_rf0, g_rf1, g_ex, g_mem, g_wb;

    task automatic rnd_data();
        g_rf0 = $urandom;
        g_rf1 = $urandom;
        g_ex  = $urandom;
        g_mem = $urandom;
        g_wb  = $urandom;
    endtask

    task automatic step(input int a0, input int a1,
                        input bit u0, input bit u1,
                        input bit v, input int rd,
                        input bit wr, input bit ld,
                        input bit br, input bit fl,
                        input bit rs,
                        output bit st, output logic [31:0] f0);
        int   ad[2];
        bit   us[2];
        logic [31:0] rf[2];
        logic [31:0] src[3];
        logic [31:0] ef;
        bit   es;
        int   best;
        int   need;
`ifdef FWD_STATS_EN
        chk("stall_cnt", {48'd0, stall_cnt}, 64'(m_cnt));
`endif
        ad[0] = a0; ad[1] = a1;
        us[0] = u0; us[1] = u1;
        rf[0] = g_rf0; rf[1] = g_rf1;
        src[0] = g_ex; src[1] = g_mem; src[2] = g_wb;
        rs_addr   = {5'(a1), 5'(a0)};
        rs_use    = {u1, u0};
        rs_data   = {g_rf1, g_rf0};
        id_valid  = v;
        rd_addr   = 5'(rd);
        reg_write = wr;
        mem_read  = ld;
        is_branch = br;
        flush     = fl;
        rst       = rs;
        ex_res    = g_ex;
        mem_res   = g_mem;
        wb_dat    = g_wb;
        #2;
        es = 0;
        for (int k = 0; k < 2; k++) begin
            best = -1;
            if (ad[k] != 0)
                for (int a = 2; a >= 0; a--)
                    if (hist[a].v && hist[a].wr && hist[a].rd == ad[k])
                        best = a;
            ef = (best < 0) ? rf[k] : src[best];
            // Result usable in ID once its age reaches the ready age.
            need = int'(ld ? 0 : 0);
            if (best >= 0) begin
                need = (hist[best].ld ? 1 : 0) + (br ? 1 : 0);
                if (v && us[k] && best < need) es = 1;
            end
            chk($sformatf("fwd%0d", k), {32'd0, fwd[k*32 +: 32]}, {32'd0, ef});
        end
        if (fl) es = 0;
        chk("stall", {63'd0, stall}, {63'd0, es});
        st = stall;
        f0 = fwd[31:0];
        if (rs) begin
            for (int a = 0; a < 3; a++) hist[a] = '{0, 0, 0, 0};
            m_cnt = 0;
        end else begin
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = '{v && !es && !fl, rd, wr, ld};
            if (es && m_cnt < 65535) m_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    bit          st;
    logic [31:0] f0;

    initial begin
        for (int a = 0; a < 3; a++) hist[a] = '{0, 0, 0, 0};
        rnd_data();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, st, f0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, st, f0);

        // ALU back-to-back
        rnd_data();
        step(0, 0, 0, 0, 1, 3, 1, 0, 0, 0, 0, st, f0);
        g_ex = 32'h1234;
        step(3, 0, 1, 0, 1, 4, 1, 0, 0, 0, 0, st, f0);
        chk("alu_fwd", {32'd0, f0}, 64'h1234);
        chk("alu_nostall", {63'd0, st}, 64'd0);

        // load-use
        rnd_data();
        step(0, 0, 0, 0, 1, 5, 1, 1, 0, 0, 0, st, f0);
        step(5, 0, 1, 0, 1, 6, 1, 0, 0, 0, 0, st, f0);
        chk("ld_use_stall", {63'd0, st}, 64'd1);
        g_mem = 32'hCAFEBABE;
        step(5, 0, 1, 0, 1, 6, 1, 0, 0, 0, 0, st, f0);
        chk("ld_use_go", {63'd0, st}, 64'd0);
        chk("ld_use_fwd", {32'd0, f0}, 64'hCAFEBABE);

        // branch on load: two stall cycles
        rnd_data();
        step(0, 0, 0, 0, 1, 7, 1, 1, 0, 0, 0, st, f0);
        step(0, 7, 0, 1, 1, 0, 0, 0, 1, 0, 0, st, f0);
        chk("br_ld_s1", {63'd0, st}, 64'd1);
        step(0, 7, 0, 1, 1, 0, 0, 0, 1, 0, 0, st, f0);
        chk("br_ld_s2", {63'd0, st}, 64'd1);
        step(0, 7, 0, 1, 1, 0, 0, 0, 1, 0, 0, st, f0);
        chk("br_ld_go", {63'd0, st}, 64'd0);

        // r0 never forwards
        rnd_data();
        step(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, st, f0);
        g_rf0 = 0;
        step(0, 0, 1, 0, 1, 1, 0, 0, 1, 0, 0, st, f0);
        chk("r0_data", {32'd0, f0}, 64'd0);
        chk("r0_nostall", {63'd0, st}, 64'd0);

        // same rd in EX and MEM: EX wins
        rnd_data();
        step(0, 0, 0, 0, 1, 9, 1, 0, 0, 0, 0, st, f0);
        step(0, 0, 0, 0, 1, 9, 1, 0, 0, 0, 0, st, f0);
        g_ex = 32'h1111;
        g_mem = 32'h2222;
        step(9, 0, 1, 0, 1, 2, 0, 0, 0, 0, 0, st, f0);
        chk("ex_wins", {32'd0, f0}, 64'h1111);

        // flush during load-use
        rnd_data();
        step(0, 0, 0, 0, 1, 5, 1, 1, 0, 0, 0, st, f0);
        step(5, 0, 1, 0, 1, 6, 1, 0, 0, 1, 0, st, f0);
        chk("flush_nostall", {63'd0, st}, 64'd0);

        // reset during a stall
        rnd_data();
        step(0, 0, 0, 0, 1, 6, 1, 1, 0, 0, 0, st, f0);
        step(6, 0, 1, 0, 1, 8, 1, 0, 0, 0, 0, st, f0);
        chk("pre_rst_stall", {63'd0, st}, 64'd1);
        step(6, 0, 1, 0, 1, 8, 1, 0, 0, 0, 1, st, f0);
        g_rf0 = 32'h0BAD_F00D;
        step(6, 0, 1, 0, 1, 8, 1, 0, 0, 0, 0, st, f0);
        chk("post_rst_stall", {63'd0, st}, 64'd0);
        chk("post_rst_fwd", {32'd0, f0}, 64'h0BADF00D);

        // random traffic over a small register set
        for (int i = 0; i < 3000; i++) begin
            rnd_data();
            step($urandom_range(0, 3), $urandom_range(0, 3),
                 1'($urandom), 1'($urandom),
                 $urandom_range(0, 9) < 8, $urandom_range(0, 3),
                 $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 3,
                 $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 1,
                 $urandom_range(0, 49) < 1, st, f0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/id_fwd_unit.md
# id_fwd_unit

Parametrised ID-stage operand forwarding and hazard unit for the 5-stage pipeline; successor to the two-port, WB-only ID bypass mux. Keeps its own shadow pipeline of destination-register tags for EX/MEM/WB, selects the youngest valid producer per read port, and raises a stall for load-use and branch-compare hazards that forwarding cannot cover. Sits between the register file read ports and the ID/EX pipeline register.

## Interface
- DATA_W, 32, datapath width
- REG_AW, 5, register address width
- NUM_RD, 2, number of ID read ports
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- id_valid_i  in  1  ID holds a real instruction
- id_rs_addr_i  in  NUM_RD*REG_AW  read addresses, port k at [k*REG_AW +: REG_AW]
- id_rs_use_i  in  NUM_RD  port k operand actually consumed
- id_rs_data_i  in  NUM_RD*DATA_W  register file read data
- id_rd_addr_i  in  REG_AW  destination of ID instruction
- id_reg_write_i  in  1  ID instruction writes rd
- id_mem_read_i  in  1  ID instruction is a load
- id_is_branch_i  in  1  ID instruction compares operands in ID
- flush_i  in  1  kill ID instruction (taken branch/jump)
- ex_result_i  in  DATA_W  ALU result of EX-stage instruction
- mem_result_i  in  DATA_W  final result of MEM-stage instruction (ALU or load data)
- wb_data_i  in  DATA_W  write-back data
- fwd_data_o  out  NUM_RD*DATA_W  forwarded operands
- stall_o  out  1  hold PC and IF/ID, inject bubble into EX
- stall_cnt_o  out  16  stall cycle count (only with FWD_STATS_EN)

## Operation
- Shadow slots EX, MEM, WB; each holds {valid, rd, reg_write, mem_read}.
- Per edge: WB<=MEM, MEM<=EX; EX<=ID fields if id_valid_i && !stall_o && !flush_i, else bubble (valid=0).
- A slot matches port k when valid && reg_write && rd==addr_k && addr_k!=0.
- Port k source priority: EX match -> ex_result_i; else MEM match -> mem_result_i; else WB match -> wb_data_i; else id_rs_data_i. Register file does not bypass internally, so WB forwarding is mandatory.
- Address 0 never forwards; fwd_data_o returns id_rs_data_i.
- Hazard on port k only when id_valid_i && id_rs_use_i[k]:
  - EX match with mem_read -> stall.
  - id_is_branch_i && EX match (any) -> stall.
  - id_is_branch_i && MEM match with mem_read -> stall.
- stall_o = OR of port hazards && !flush_i. Flush has priority: killed instruction never stalls.
- Ports with id_rs_use_i=0 still drive forwarded data but never cause stalls.
- Load-use non-branch: exactly 1 stall cycle. Branch on ALU result: 1. Branch on load: 2.

## Timing
- fwd_data_o and stall_o are combinational from inputs and shadow slots; no added latency.
- Shadow slots update on rising clk_i only.
- Reset: all slots valid=0; stall_o=0 and fwd_data_o=id_rs_data_i from the first cycle after reset; stall_cnt_o=0.
- rst_i mid-stall clears slots on the same edge; stall cannot persist past reset.
- stall_o && flush_i together is impossible at the output; EX gets a bubble.
- Same rd in EX and MEM: EX (youngest) wins.

## Configuration
- FWD_STATS_EN defined: stall_cnt_o present; increments by 1 each cycle stall_o=1, saturates at 16'hFFFF, cleared only by rst_i.
- Undefined: port and counter absent; no other behaviour changes.

## Structure
- Shared package: slot struct {valid, rd, reg_write, mem_read}, source-select enum {SRC_RF, SRC_EX, SRC_MEM, SRC_WB}, REG_ZERO constant.
- One sub-module: fwd_port_sel, per-port priority match, source mux and hazard flag; instantiated NUM_RD times via generate.

## Test plan
- Back-to-back ALU: add r3 in EX, ID reads r3 on port 0 -> fwd_data_o[0]=ex_result_i (0x1234), stall_o=0.
- Load-use: lw r5 in EX, ID uses r5 -> stall_o=1 for 1 cycle, then forwarded from mem_result_i (0xCAFEBABE).
- Branch on load: lw r7 then beq r7 -> stall_o=1 for 2 consecutive cycles, then MEM/WB forward.
- r0 target: EX writes r0, ID reads r0 -> no forward, no stall, fwd_data_o=0.
- EX and MEM both write r9 -> EX value selected; flush_i during load-use -> stall_o=0, EX bubble.
- rst_i asserted during a stall -> next cycle stall_o=0, slots empty; with FWD_STATS_EN stall_cnt_o=0.
